// File: rtl/boot_pkg.sv
// ============================================================================
// boot_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the boot sequencer:
//   - boot_state_e : load FSM states (HEADER, LOAD, CHECK, RUN, ERROR)
//   - BOOT_MAGIC   : value expected in the header magic field
//   - HDR_*        : bit positions of the header fields
//   - header_valid : header acceptance test (magic match and 1 <= N <= max)
// No ports; imported with `import boot_pkg::*;`.
// ============================================================================
package boot_pkg;

    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_RUN    = 3'd3,
        S_ERROR  = 3'd4
    } boot_state_e;

    localparam logic [15:0] BOOT_MAGIC = 16'hB007;

    // Header layout: [31:16] magic, [12:0] payload length N. Bits [15:13]
    // are ignored.
    localparam int HDR_MAGIC_HI = 31;
    localparam int HDR_MAGIC_LO = 16;
    localparam int HDR_LEN_HI   = 12;
    localparam int HDR_LEN_LO   = 0;
    localparam int HDR_LEN_W    = HDR_LEN_HI - HDR_LEN_LO + 1;

    // A header is accepted only when the magic matches and the length is
    // non-zero and no larger than the instruction memory allows.
    function automatic logic header_valid(input logic [31:0] hdr,
                                          input int unsigned max_words);
        logic [15:0]          magic;
        logic [HDR_LEN_W-1:0] len;
        magic = hdr[HDR_MAGIC_HI:HDR_MAGIC_LO];
        len   = hdr[HDR_LEN_HI:HDR_LEN_LO];
        return (magic == BOOT_MAGIC) &&
               (len != '0) &&
               ({{(32-HDR_LEN_W){1'b0}}, len} <= max_words);
    endfunction

endpackage

// File: rtl/boot_edge_detect.sv
// ============================================================================
// boot_edge_detect
// ----------------------------------------------------------------------------
// Turns the receiver's word-valid level into a one-cycle accept pulse. The
// previous level is registered; the pulse is high while the level is 1 and
// the registered copy is still 0, so a level held high gives one pulse.
//
// Ports:
//   clk_i     in   clock
//   rst_ni    in   asynchronous active-low reset
//   level_i   in   word-valid level from the receiver
//   pulse_o   out  accept pulse (combinational from level_i and prev_q)
// ============================================================================
module boot_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/boot_sequencer.sv
// ============================================================================
// boot_sequencer
// ----------------------------------------------------------------------------
// Holds the CPU in reset while a program image arrives from the serial word
// receiver: header -> N payload words written to instruction memory at
// consecutive addresses -> checksum word (sum of payload mod 2^32). The CPU is
// released only after a matching checksum.
//
// Optional feature macro: BOOT_TIMEOUT_EN
//   defined   : an inter-word timer runs in LOAD/CHECK; reaching
//               TIMEOUT_CYCLES without an accept forces ERROR.
//   undefined : LOAD/CHECK wait indefinitely.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   word_ready    in   receiver word-valid level (accept on 0->1)
//   word_data     in   receiver word, stable while word_ready=1
//   start         in   one-cycle reload request (wins over a coincident word)
//   imem_wen      out  one-cycle write strobe, cycle after the accept edge
//   imem_waddr    out  write address
//   imem_wdata    out  write data
//   cpu_reset     out  active-high CPU reset, low only in RUN
//   busy          out  LOAD or CHECK in progress
//   error         out  sticky load failure, cleared by start
//   words_loaded  out  payload words written in the current/last load
//
// Handshake: the receiver presents a word by raising word_ready and keeping
// word_data stable while it is high; exactly one word is taken per rising
// edge of word_ready, and there is no back-pressure toward the receiver.
// All outputs are registers.
// ============================================================================
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int MAX_WORDS      = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_ready,
    input  logic [DATA_W-1:0] word_data,
    input  logic              start,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = ADDR_W + 1;

    // Elaboration-time sanity checks on the configuration.
    if (DATA_W < 32) begin : g_bad_data_w
        $error("boot_sequencer: DATA_W must be at least 32 to hold a header");
    end
    if (MAX_WORDS < 1 || MAX_WORDS > (1 << ADDR_W)) begin : g_bad_max_words
        $error("boot_sequencer: MAX_WORDS must be in 1..2**ADDR_W");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("boot_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    // ------------------------------------------------------------------
    // Accept pulse
    // ------------------------------------------------------------------
    logic accept;

    boot_edge_detect u_edge (
        .clk_i   (clk),
        .rst_ni  (reset),
        .level_i (word_ready),
        .pulse_o (accept)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    boot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;      // address counter == words written
    logic [CNT_W-1:0]  len_q, len_d;      // latched payload length N
    logic [31:0]       csum_q, csum_d;    // running payload sum mod 2^32
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpu_reset_q, busy_q, error_q;

    logic [CNT_W-1:0]  cnt_inc;
    logic              hdr_ok;
    logic              tmo_hit;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign hdr_ok  = header_valid(word_data[31:0], MAX_WORDS);

    // ------------------------------------------------------------------
    // Optional inter-word timeout
    // ------------------------------------------------------------------
`ifdef BOOT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Runs only while waiting for a word in LOAD/CHECK. Outside those states
    // it stays at zero, so the entry into LOAD starts from a cleared count.
    always_comb begin
        tmo_d = '0;
        if ((state_q == S_LOAD || state_q == S_CHECK) && !accept && !start) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_q >= TMO_W'(TIMEOUT_CYCLES));
`else
    assign tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        csum_d  = csum_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (start) begin
            // A reload from any state; a word accepted in the same cycle is
            // dropped. Memory already written is left as is.
            state_d = S_HEADER;
        end else begin
            unique case (state_q)
                S_HEADER: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            len_d   = CNT_W'(word_data[HDR_LEN_HI:HDR_LEN_LO]);
                            cnt_d   = '0;
                            csum_d  = '0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        wen_d   = 1'b1;
                        waddr_d = cnt_q[ADDR_W-1:0];
                        wdata_d = word_data;
                        csum_d  = csum_q + word_data[31:0];
                        cnt_d   = cnt_inc;
                        // cnt_q is one bit wider than the address, so N equal
                        // to the full memory size ends at 2**ADDR_W without
                        // wrapping back to address 0.
                        if (cnt_inc == len_q) begin
                            state_d = S_CHECK;
                        end
                    end else if (tmo_hit) begin
                        state_d = S_ERROR;
                    end
                end

                S_CHECK: begin
                    if (accept) begin
                        state_d = (word_data[31:0] == csum_q) ? S_RUN : S_ERROR;
                    end else if (tmo_hit) begin
                        state_d = S_ERROR;
                    end
                end

                S_RUN:   state_d = S_RUN;
                S_ERROR: state_d = S_ERROR;

                default: state_d = S_HEADER;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers. Status outputs are registered from the next state so they
    // change in the same cycle the FSM moves (e.g. cpu_reset falls in the
    // cycle after the edge that samples a matching checksum).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_HEADER;
            cnt_q       <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= (state_d != S_RUN);
            busy_q      <= (state_d == S_LOAD) || (state_d == S_CHECK);
            error_q     <= (state_d == S_ERROR);
        end
    end

    assign imem_wen     = wen_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// ============================================================================
// tb_boot_sequencer
// ----------------------------------------------------------------------------
// Directed bench for boot_sequencer. Expected memory writes are queued as
// {addr, data} when a payload word is driven and popped on each observed
// imem_wen strobe. Outputs are sampled on the falling clock edge.
// ============================================================================
module tb_boot_sequencer;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int MAX_WORDS  = 4096;
    localparam int TB_TIMEOUT = 200;
    localparam int EXP_W      = ADDR_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              word_ready = 1'b0;
    logic [DATA_W-1:0] word_data  = '0;
    logic              start      = 1'b0;
    logic              imem_wen;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    boot_sequencer #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_WORDS      (MAX_WORDS),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .start        (start),
        .imem_wen     (imem_wen),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0]  exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                wr_count = 0;
    logic [ADDR_W-1:0] last_waddr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Sample the write port; every strobe must match the head of the queue.
    task automatic observe();
        logic [EXP_W-1:0] got;
        if (imem_wen !== 1'b0) begin
            wr_count++;
            last_waddr = imem_waddr;
            got = {imem_waddr, imem_wdata};
            chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("write_addr_data", 64'(got), 64'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        observe();
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input int hold);
        step();
        word_ready = 1'b1;
        word_data  = d;
        repeat (hold) step();
        word_ready = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        chk({tag, "_wen"}, 64'(imem_wen), 64'd0);
        chk({tag, "_waddr"}, 64'(imem_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] bad_hdr [3];
    logic [31:0] sum;
    logic [31:0] d;

    initial begin
        bad_hdr[0] = 32'hB007_0000;
        bad_hdr[1] = 32'hB007_1001;
        bad_hdr[2] = 32'hDEAD_0003;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Clean load: 1, 2, 3, checksum 6
        send_word(32'hB007_0003, 1);
        chk("clean_busy_load", 64'(busy), 64'd1);
        push_exp(12'd0, 32'd1);
        push_exp(12'd1, 32'd2);
        push_exp(12'd2, 32'd3);
        send_word(32'd1, 1);
        send_word(32'd2, 1);
        send_word(32'd3, 1);
        chk("clean_busy_check", 64'(busy), 64'd1);
        step();
        word_ready = 1'b1;
        word_data  = 32'd6;
        chk("clean_cpu_reset_before", 64'(cpu_reset), 64'd1);
        step();
        chk("clean_cpu_release", 64'(cpu_reset), 64'd0);
        word_ready = 1'b0;
        step();
        chk("clean_busy_run", 64'(busy), 64'd0);
        chk("clean_error", 64'(error), 64'd0);
        chk("clean_words_loaded", 64'(words_loaded), 64'd3);
        chk("clean_wr_count", 64'(wr_count), 64'd3);
        chk("clean_queue_empty", 64'(exp_q.size()), 64'd0);

        // Bad checksum
        pulse_start();
        step();
        chk("restart_cpu_reset", 64'(cpu_reset), 64'd1);
        send_word(32'hB007_0003, 1);
        push_exp(12'd0, 32'd1);
        push_exp(12'd1, 32'd2);
        push_exp(12'd2, 32'd3);
        send_word(32'd1, 1);
        send_word(32'd2, 1);
        send_word(32'd3, 1);
        send_word(32'd7, 1);
        repeat (4) step();
        chk("badsum_error", 64'(error), 64'd1);
        chk("badsum_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("badsum_busy", 64'(busy), 64'd0);
        pulse_start();
        step();
        chk("badsum_start_clears_error", 64'(error), 64'd0);
        chk("badsum_start_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("badsum_start_busy", 64'(busy), 64'd0);

        // Bad headers
        for (int i = 0; i < 3; i++) begin
            wr_count = 0;
            send_word(bad_hdr[i], 1);
            step();
            chk($sformatf("badhdr%0d_error", i), 64'(error), 64'd1);
            chk($sformatf("badhdr%0d_busy", i), 64'(busy), 64'd0);
            send_word(32'h1234_5678, 1);
            chk($sformatf("badhdr%0d_no_writes", i), 64'(wr_count), 64'd0);
            pulse_start();
            step();
            chk($sformatf("badhdr%0d_cleared", i), 64'(error), 64'd0);
        end

        // Held level: one word, ready high for 10 cycles -> one strobe
        wr_count = 0;
        send_word(32'hB007_0002, 1);
        push_exp(12'd0, 32'hAAAA_5555);
        send_word(32'hAAAA_5555, 10);
        chk("held_one_strobe", 64'(wr_count), 64'd1);
        chk("held_words_loaded", 64'(words_loaded), 64'd1);

        // Coincident start and accept of the second payload word
        step();
        word_ready = 1'b1;
        word_data  = 32'hCAFE_F00D;
        start      = 1'b1;
        step();
        start      = 1'b0;
        word_ready = 1'b0;
        step();
        step();
        chk("coinc_dropped", 64'(wr_count), 64'd1);
        chk("coinc_busy", 64'(busy), 64'd0);
        chk("coinc_error", 64'(error), 64'd0);
        chk("coinc_cpu_reset", 64'(cpu_reset), 64'd1);

        // Asynchronous reset during LOAD with a write strobe pending
        send_word(32'hB007_0004, 1);
        push_exp(12'd0, 32'h11);
        send_word(32'h11, 1);
        step();
        word_ready = 1'b1;
        word_data  = 32'h22;
        @(posedge clk);
        #1;
        chk("areset_pending_wen", 64'(imem_wen), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("areset");
        word_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("areset_after_busy", 64'(busy), 64'd0);
        chk("areset_queue_empty", 64'(exp_q.size()), 64'd0);

        // Maximum length: N = 4096
        wr_count = 0;
        sum = '0;
        send_word(32'hB007_1000, 1);
        for (int i = 0; i < MAX_WORDS; i++) begin
            d = $urandom;
            sum += d;
            push_exp(ADDR_W'(i), d);
            send_word(d, 1);
        end
        chk("max_wr_count", 64'(wr_count), 64'd4096);
        chk("max_last_addr", 64'(last_waddr), 64'd4095);
        chk("max_words_loaded", 64'(words_loaded), 64'd4096);
        chk("max_busy_check", 64'(busy), 64'd1);
        send_word(sum, 1);
        chk("max_cpu_release", 64'(cpu_reset), 64'd0);
        chk("max_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef BOOT_TIMEOUT_EN
        // Stall mid-load longer than the timeout
        pulse_start();
        send_word(32'hB007_0002, 1);
        push_exp(12'd0, 32'h55);
        send_word(32'h55, 1);
        repeat (TB_TIMEOUT + 10) step();
        chk("timeout_error", 64'(error), 64'd1);
        chk("timeout_busy", 64'(busy), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Controls program loading for the FPGA build. It holds the processor in reset and takes words from the serial word receiver. It validates a header, writes the payload into instruction memory at consecutive addresses, and checks a trailing checksum. The CPU is released only after a clean load. It sits between the word receiver and the instruction-memory write port, and it drives the CPU reset.

## Interface
- ADDR_W, 12, instruction-memory word-address width
- DATA_W, 32, word width
- MAX_WORDS, 4096, largest accepted payload length
- TIMEOUT_CYCLES, 1000000, inter-word timeout (used only with BOOT_TIMEOUT_EN)

- clk  in  1  system clock; the single clock
- reset  in  1  asynchronous, active-low reset
- word_ready  in  1  receiver word-valid level; a word is taken on each 0→1 transition
- word_data  in  DATA_W  receiver word, stable while word_ready=1
- start  in  1  one-cycle reload request
- imem_wen  out  1  instruction-memory write strobe
- imem_waddr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_reset  out  1  active-high processor reset
- busy  out  1  a load is in progress (LOAD or CHECK)
- error  out  1  sticky load failure
- words_loaded  out  ADDR_W+1  payload words written in the current or last load

## Operation
- **Accept event:** `word_ready` is 1 and the registered previous `word_ready` is 0. A level held high yields exactly one accept.
- **Header format:**
  - [31:16] must equal BOOT_MAGIC (16'hB007).
  - [12:0] is the payload length N.
  - Valid only when the magic matches and 1 ≤ N ≤ MAX_WORDS.
- **HEADER** (entered from reset)
  - On accept of a valid header: latch N, clear the address counter, checksum and `words_loaded`, then go to LOAD.
  - On accept of an invalid header: go to ERROR.
- **LOAD**
  - On each accept: write `word_data` at the address counter, add the word to the checksum (mod 2^32), and increment the address counter and `words_loaded`.
  - After the Nth write, go to CHECK.
- **CHECK**
  - On accept: if the word equals the checksum, go to RUN; otherwise go to ERROR.
- **RUN:** `cpu_reset`=0. `start` goes to HEADER.
- **ERROR:** `error`=1 and `cpu_reset`=1. `start` clears `error` and goes to HEADER.
- **`start` in HEADER, LOAD or CHECK:** restarts at HEADER and discards the partial load. Memory contents already written are not cleared.
- **Coincident `start` and accept:** `start` wins and the word is dropped.
- **Address counter:** width ADDR_W+1. N=MAX_WORDS writes addresses 0..MAX_WORDS-1, and the counter never wraps into address 0 within one load.
- **`cpu_reset`:** 1 in every state except RUN.

## Timing
- **Reset values:**
  - state=HEADER
  - `cpu_reset`=1
  - `imem_wen`=0, `imem_waddr`=0, `imem_wdata`=0
  - `busy`=0, `error`=0, `words_loaded`=0
- **Registered outputs:** all outputs are registered.
- **Write latency:** `imem_wen` is high for exactly one cycle, in the cycle after the edge that samples the accept. Address and data are valid in that same cycle.
- **Throughput:** one accept per two cycles minimum, because `word_ready` must return to 0 between words.
- **CPU release:** `cpu_reset` falls in the cycle after the edge that samples the accept of a matching checksum word.
- **Reset mid-load:** asynchronous assertion returns every output to its reset value immediately. Any pending write strobe is killed.

## Configuration
- **BOOT_TIMEOUT_EN defined:**
  - A counter runs in LOAD and CHECK. It clears on each accept and on entry to LOAD.
  - Reaching TIMEOUT_CYCLES goes to ERROR.
- **BOOT_TIMEOUT_EN undefined:** no counter. LOAD and CHECK wait indefinitely.

## Structure
- **Package `boot_pkg`** holds:
  - the state enum (HEADER, LOAD, CHECK, RUN, ERROR)
  - BOOT_MAGIC
  - the header field bit positions
- **Sub-module `boot_edge_detect`:** registers the previous `word_ready` and outputs the one-cycle accept pulse, with asynchronous active-low reset.
- **Top level:** the FSM, counters, checksum and output registers live in `boot_sequencer`.

## Test plan
- **Clean load:** header 32'hB007_0003, words 1, 2, 3, checksum 6.
  - Writes at addr 0/1/2 with data 1/2/3.
  - `cpu_reset` falls one cycle after the checksum accept.
  - `words_loaded`=3.
- **Bad checksum:** same load but checksum 7.
  - ERROR with `error`=1 and `cpu_reset` held at 1.
  - `start` then clears `error` and returns to HEADER.
- **Bad headers:** 32'hB007_0000, 32'hB007_1001 and 32'hDEAD_0003.
  - Each goes to ERROR with zero writes.
- **Held level:** `word_ready` held high for 10 cycles on one payload word → exactly one `imem_wen` pulse.
- **Coincident and async events:**
  - `start` on the same cycle as the accept of the second payload word → word dropped, state HEADER.
  - Asynchronous reset during LOAD → all outputs return to reset values.
- **Maximum length:** N=4096 payload words → last write at addr 4095 and `words_loaded`=4096.
  - With BOOT_TIMEOUT_EN and a stall of TIMEOUT_CYCLES mid-load → ERROR.
